// File: rtl/cdr_pkg.sv
// Shared CDR loop definitions: sequencer states and the loop-filter gain encodings
// that both this sequencer and the loop filter decode.
package cdr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } cdr_state_e;

  localparam logic [1:0] GAIN_FREEZE = 2'b00;
  localparam logic [1:0] GAIN_ACQ    = 2'b10;
  localparam logic [1:0] GAIN_TRACK  = 2'b01;

  function automatic logic [1:0] gain_for(cdr_state_e s);
    case (s)
      ST_IDLE: return GAIN_FREEZE;
      ST_ACQ:  return GAIN_ACQ;
      default: return GAIN_TRACK;
    endcase
  endfunction

endpackage

// File: rtl/cdr_win_accum.sv
// Observation-window engine: counts cycles per window, accumulates Up/Dn events and
// reports |up - dn| for the window, including the event of the closing cycle.
module cdr_win_accum #(
  parameter int WINDOW_LEN = 256,
  localparam int CW = $clog2(WINDOW_LEN + 1),
  localparam int WW = $clog2(WINDOW_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          clr,
  input  logic          up,
  input  logic          dn,
  output logic          window_done,
  output logic [CW-1:0] abs_net
);

  localparam logic [WW-1:0] LAST = WW'(WINDOW_LEN - 1);

  logic [WW-1:0]   wcnt;
  logic [CW-1:0]   up_cnt, dn_cnt;
  logic [CW-1:0]   up_sum, dn_sum;
  logic            up_ev, dn_ev;
  logic signed [CW:0] net;

  // Both-high and both-low decisions carry no phase information.
  assign up_ev = up & ~dn;
  assign dn_ev = dn & ~up;

  assign up_sum = up_cnt + CW'(up_ev);
  assign dn_sum = dn_cnt + CW'(dn_ev);

  assign window_done = (wcnt == LAST);

  assign net     = $signed({1'b0, up_sum}) - $signed({1'b0, dn_sum});
  assign abs_net = net[CW] ? CW'(-net) : CW'(net);

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt   <= '0;
      up_cnt <= '0;
      dn_cnt <= '0;
    end else if (clr || !run || window_done) begin
      wcnt   <= '0;
      up_cnt <= '0;
      dn_cnt <= '0;
    end else begin
      wcnt   <= wcnt + WW'(1);
      up_cnt <= up_sum;
      dn_cnt <= dn_sum;
    end
  end

endmodule

// File: rtl/cdr_gear_ctrl.sv
// Bang-bang CDR acquisition/lock sequencer: gear-shifts the loop filter from
// acquisition to tracking gain and declares or drops lock from windowed Up/Dn balance.
module cdr_gear_ctrl
  import cdr_pkg::*;
#(
  parameter int WINDOW_LEN     = 256,
  parameter int ACQ_WINDOWS    = 8,
  parameter int LOCK_WINDOWS   = 4,
  parameter int LOCK_THRESH    = 16,
  parameter int UNLOCK_THRESH  = 64,
  parameter int UNLOCK_WINDOWS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       Up,
  input  logic       Dn,
  output logic [1:0] gain_sel,
  output logic       locked,
  output logic [1:0] state,
  output logic       window_done
);

  localparam int CW = $clog2(WINDOW_LEN + 1);
  localparam int AW = $clog2(ACQ_WINDOWS + 1);
  localparam int QW = $clog2(LOCK_WINDOWS + 1);
  localparam int VW = $clog2(UNLOCK_WINDOWS + 1);

  localparam logic [31:0] LOCK_TH   = 32'(LOCK_THRESH);
  localparam logic [31:0] UNLOCK_TH = 32'(UNLOCK_THRESH);

  cdr_state_e    state_q, state_nxt;
  logic [AW-1:0] acq_cnt, acq_nxt, acq_inc;
  logic [QW-1:0] quiet_cnt, quiet_nxt, quiet_inc;
  logic [VW-1:0] viol_cnt, viol_nxt, viol_inc;
  logic [CW-1:0] abs_net;
  logic [31:0]   abs_ext;
  logic          is_quiet, is_viol;

  cdr_win_accum #(
    .WINDOW_LEN (WINDOW_LEN)
  ) u_win (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (state_q != ST_IDLE),
    .clr         (!en),
    .up          (Up),
    .dn          (Dn),
    .window_done (window_done),
    .abs_net     (abs_net)
  );

  assign abs_ext  = 32'(abs_net);
  assign is_quiet = (abs_ext <= LOCK_TH);
  assign is_viol  = (abs_ext >  UNLOCK_TH);

  assign acq_inc   = acq_cnt + AW'(1);
  assign quiet_inc = quiet_cnt + QW'(1);
  assign viol_inc  = viol_cnt + VW'(1);

  // NOTE: every combinational output is defaulted first so no path can infer a latch.
  always_comb begin
    state_nxt = state_q;
    acq_nxt   = acq_cnt;
    quiet_nxt = quiet_cnt;
    viol_nxt  = viol_cnt;

    if (!en) begin
      state_nxt = ST_IDLE;
      acq_nxt   = '0;
      quiet_nxt = '0;
      viol_nxt  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_nxt = ST_ACQ;
          acq_nxt   = '0;
          quiet_nxt = '0;
          viol_nxt  = '0;
        end
        ST_ACQ: begin
          if (window_done) begin
            acq_nxt = acq_inc;
            if (acq_inc == AW'(ACQ_WINDOWS)) begin
              state_nxt = ST_TRACK;
              quiet_nxt = '0;
            end
          end
        end
        ST_TRACK: begin
          if (window_done) begin
            if (is_quiet) begin
              quiet_nxt = quiet_inc;
              if (quiet_inc == QW'(LOCK_WINDOWS)) begin
                state_nxt = ST_LOCKED;
                viol_nxt  = '0;
              end
            end else begin
              quiet_nxt = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (window_done) begin
            if (is_viol) begin
              viol_nxt = viol_inc;
              // Persistent violation: fall back to high-gain acquisition.
              if (viol_inc == VW'(UNLOCK_WINDOWS)) begin
                state_nxt = ST_ACQ;
                acq_nxt   = '0;
              end
            end else begin
              viol_nxt = '0;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: only control state is reset; there is no memory array here to leave unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      acq_cnt   <= '0;
      quiet_cnt <= '0;
      viol_cnt  <= '0;
      gain_sel  <= GAIN_FREEZE;
      locked    <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      acq_cnt   <= acq_nxt;
      quiet_cnt <= quiet_nxt;
      viol_cnt  <= viol_nxt;
      gain_sel  <= gain_for(state_nxt);
      locked    <= (state_nxt == ST_LOCKED);
    end
  end

  assign state = state_q;

endmodule
